// File: rtl/execute_stage_nlane_if.sv
// execute_stage_nlane_if
//   Bundles the EX-side inputs and the EX/MEM-side outputs of the N-lane
//   execute stage. Vector signals carry lane i at [i*W +: W].
//   slave  : the execute stage (consumes E-side inputs, drives M outputs)
//   master : upstream/downstream environment (drives E-side, reads outputs)
//   Inputs : ValidE, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE,
//            ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
//            ForwardA_E, ForwardB_E, FwdLaneA_E, FwdLaneB_E, ResultW,
//            StallM, FlushM
//   Outputs: PCSrcE, PCTargetE, BrLaneE (combinational), ValidM, RegWriteM,
//            MemWriteM, ResultSrcM, RD_M, ALU_ResultM, WriteDataM, PCPlus4M
interface execute_stage_nlane_if #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
);
    logic [LANES-1:0]      ValidE, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
    logic [3*LANES-1:0]    ALUControlE;
    logic [XLEN*LANES-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [5*LANES-1:0]    RD_E;
    logic [2*LANES-1:0]    ForwardA_E, ForwardB_E;
    logic [LW*LANES-1:0]   FwdLaneA_E, FwdLaneB_E;
    logic                  StallM, FlushM;

    logic                  PCSrcE;
    logic [XLEN-1:0]       PCTargetE;
    logic [LW-1:0]         BrLaneE;
    logic [LANES-1:0]      ValidM, RegWriteM, MemWriteM, ResultSrcM;
    logic [5*LANES-1:0]    RD_M;
    logic [XLEN*LANES-1:0] ALU_ResultM, WriteDataM, PCPlus4M;

    modport slave (
        input  ValidE, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE,
               ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW,
               RD_E, ForwardA_E, ForwardB_E, FwdLaneA_E, FwdLaneB_E,
               StallM, FlushM,
        output PCSrcE, PCTargetE, BrLaneE, ValidM, RegWriteM, MemWriteM,
               ResultSrcM, RD_M, ALU_ResultM, WriteDataM, PCPlus4M
    );

    modport master (
        output ValidE, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE,
               ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW,
               RD_E, ForwardA_E, ForwardB_E, FwdLaneA_E, FwdLaneB_E,
               StallM, FlushM,
        input  PCSrcE, PCTargetE, BrLaneE, ValidM, RegWriteM, MemWriteM,
               ResultSrcM, RD_M, ALU_ResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/execute_stage_nlane.sv
// execute_stage_nlane
//   N-lane execute stage of the multi-issue core. Per lane: operand
//   forwarding from any lane's M or W result, 8-op ALU, branch resolution.
//   Owns the EX/MEM register with stall, flush and squash of lanes younger
//   than the oldest taken branch (lane 0 is oldest).
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (clears every registered output)
//   bus : execute_stage_nlane_if.slave (E-side inputs, redirect, M outputs)
module execute_stage_nlane #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    execute_stage_nlane_if.slave  bus
);

    // Forward mux: 01 = W result, 10 = current M result, 00/11 = regfile.
    // A lane index beyond LANES (possible when LANES is not a power of two)
    // falls back to the regfile value.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [XLEN-1:0]       rf,
        input logic [1:0]            sel,
        input logic [LW-1:0]         src,
        input logic [XLEN*LANES-1:0] w_vec,
        input logic [XLEN*LANES-1:0] m_vec
    );
        int s;
        s = int'(src);
        fwd_sel = rf;
        if (s < LANES) begin
            if (sel == 2'b01)      fwd_sel = w_vec[s*XLEN +: XLEN];
            else if (sel == 2'b10) fwd_sel = m_vec[s*XLEN +: XLEN];
        end
    endfunction

    function automatic logic [XLEN-1:0] alu_op(
        input logic [2:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic signed [XLEN-1:0] sa, sb;
        sa     = a;
        sb     = b;
        alu_op = '0;
        case (op)
            3'b000: alu_op    = a + b;
            3'b001: alu_op    = a - b;
            3'b010: alu_op    = a & b;
            3'b011: alu_op    = a | b;
            3'b100: alu_op    = a ^ b;
            3'b101: alu_op[0] = (sa < sb);
            3'b110: alu_op    = a << b[4:0];
            3'b111: alu_op    = a >> b[4:0];
        endcase
    endfunction

    logic [LANES-1:0]      valid_q, regwrite_q, memwrite_q, resultsrc_q;
    logic [LANES-1:0]      valid_d, regwrite_d, memwrite_d, resultsrc_d;
    logic [5*LANES-1:0]    rd_q, rd_d;
    logic [XLEN*LANES-1:0] alu_q, alu_d, wd_q, wd_d, pc4_q, pc4_d;

    logic [XLEN*LANES-1:0] alu_res, srcb_int, target;
    logic [LANES-1:0]      taken, squash;
    logic                  any_taken;
    logic [LW-1:0]         br_lane;

    // ---- EX: operand selection, ALU, branch condition per lane ----
    always_comb begin
        logic [XLEN-1:0] a, bint, b, r;
        a        = '0;
        bint     = '0;
        b        = '0;
        r        = '0;
        alu_res  = '0;
        srcb_int = '0;
        target   = '0;
        taken    = '0;
        for (int i = 0; i < LANES; i++) begin
            a    = fwd_sel(bus.RD1_E[i*XLEN +: XLEN], bus.ForwardA_E[2*i +: 2],
                           bus.FwdLaneA_E[LW*i +: LW], bus.ResultW, alu_q);
            bint = fwd_sel(bus.RD2_E[i*XLEN +: XLEN], bus.ForwardB_E[2*i +: 2],
                           bus.FwdLaneB_E[LW*i +: LW], bus.ResultW, alu_q);
            b    = bus.ALUSrcE[i] ? bus.Imm_Ext_E[i*XLEN +: XLEN] : bint;
            r    = alu_op(bus.ALUControlE[3*i +: 3], a, b);
            alu_res[i*XLEN +: XLEN]  = r;
            srcb_int[i*XLEN +: XLEN] = bint;
            target[i*XLEN +: XLEN]   = bus.PCE[i*XLEN +: XLEN] + bus.Imm_Ext_E[i*XLEN +: XLEN];
            taken[i] = bus.ValidE[i] & bus.BranchE[i] & (r == '0);
        end
    end

    // Oldest taken branch wins; every lane after it in the bundle is squashed.
    always_comb begin
        any_taken = 1'b0;
        br_lane   = '0;
        squash    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (any_taken) begin
                squash[i] = 1'b1;
            end else if (taken[i]) begin
                any_taken = 1'b1;
                br_lane   = LW'(i);
            end
        end
    end

    // The redirect is held back while M stalls; upstream keeps the EX inputs
    // steady so it issues exactly once, in the cycle the stall releases.
    assign bus.PCSrcE    = any_taken & ~bus.StallM;
    assign bus.PCTargetE = target[int'(br_lane)*XLEN +: XLEN];
    assign bus.BrLaneE   = br_lane;

    // ---- EX/MEM register next state: flush > stall > load ----
    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        memwrite_d  = memwrite_q;
        resultsrc_d = resultsrc_q;
        rd_d        = rd_q;
        alu_d       = alu_q;
        wd_d        = wd_q;
        pc4_d       = pc4_q;
        if (bus.FlushM) begin
            valid_d     = '0;
            regwrite_d  = '0;
            memwrite_d  = '0;
            resultsrc_d = '0;
            rd_d        = '0;
            alu_d       = '0;
            wd_d        = '0;
            pc4_d       = '0;
        end else if (!bus.StallM) begin
            valid_d     = bus.ValidE & ~squash;
            regwrite_d  = bus.RegWriteE & valid_d;
            memwrite_d  = bus.MemWriteE & valid_d;
            resultsrc_d = bus.ResultSrcE;
            rd_d        = bus.RD_E;
            alu_d       = alu_res;
            wd_d        = srcb_int;
            pc4_d       = bus.PCPlus4E;
        end
    end

    // ---- MEM: EX/MEM pipeline register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            regwrite_q  <= '0;
            memwrite_q  <= '0;
            resultsrc_q <= '0;
            rd_q        <= '0;
            alu_q       <= '0;
            wd_q        <= '0;
            pc4_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            memwrite_q  <= memwrite_d;
            resultsrc_q <= resultsrc_d;
            rd_q        <= rd_d;
            alu_q       <= alu_d;
            wd_q        <= wd_d;
            pc4_q       <= pc4_d;
        end
    end

    assign bus.ValidM      = valid_q;
    assign bus.RegWriteM   = regwrite_q;
    assign bus.MemWriteM   = memwrite_q;
    assign bus.ResultSrcM  = resultsrc_q;
    assign bus.RD_M        = rd_q;
    assign bus.ALU_ResultM = alu_q;
    assign bus.WriteDataM  = wd_q;
    assign bus.PCPlus4M    = pc4_q;

endmodule

// File: tb/tb_execute_stage_nlane.sv
module tb_execute_stage_nlane;
    localparam int N = 2;
    localparam int X = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execute_stage_nlane_if #(.LANES(N), .XLEN(X)) bus ();
    execute_stage_nlane #(.LANES(N), .XLEN(X)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // Per-lane stimulus
    bit        v[N], rw[N], mw[N], rs[N], br[N], asrc[N], la[N], lb[N];
    bit [2:0]  op[N];
    bit [1:0]  fa[N], fb[N];
    bit [4:0]  rdn[N];
    bit [31:0] rd1[N], rd2[N], imm[N], pc[N], pc4[N], resw[N];
    bit        stall, flush;

    // Reference model: M-stage contents and expected redirect
    bit        m_v[N], m_rw[N], m_mw[N], m_rs[N];
    bit [4:0]  m_rd[N];
    bit [31:0] m_alu[N], m_wd[N], m_pc4[N];
    bit        n_v[N], n_rw[N], n_mw[N], n_rs[N];
    bit [4:0]  n_rd[N];
    bit [31:0] n_alu[N], n_wd[N], n_pc4[N];
    bit        e_pcsrc;
    bit [31:0] e_tgt;
    int        e_br;

    // Redirect observed during the last cycle
    logic        o_pcsrc;
    logic [31:0] o_tgt;
    logic        o_br;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] ref_alu(input bit [2:0] o, input bit [31:0] a, input bit [31:0] b);
        case (o)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd6: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    function automatic bit [31:0] opnd(input bit [1:0] sel, input bit src, input bit [31:0] rf);
        if (sel == 2'd1) return resw[src];
        if (sel == 2'd2) return m_alu[src];
        return rf;
    endfunction

    task automatic clear_inputs();
        for (int l = 0; l < N; l++) begin
            v[l] = 0; rw[l] = 0; mw[l] = 0; rs[l] = 0; br[l] = 0; asrc[l] = 0;
            la[l] = 0; lb[l] = 0; op[l] = 0; fa[l] = 0; fb[l] = 0; rdn[l] = 0;
            rd1[l] = 0; rd2[l] = 0; imm[l] = 0; pc[l] = 0; pc4[l] = 0; resw[l] = 0;
        end
        stall = 0;
        flush = 0;
    endtask

    task automatic pack_inputs();
        for (int l = 0; l < N; l++) begin
            bus.ValidE[l]     = v[l];
            bus.RegWriteE[l]  = rw[l];
            bus.MemWriteE[l]  = mw[l];
            bus.ResultSrcE[l] = rs[l];
            bus.BranchE[l]    = br[l];
            bus.ALUSrcE[l]    = asrc[l];
            bus.ALUControlE[3*l +: 3] = op[l];
            bus.ForwardA_E[2*l +: 2]  = fa[l];
            bus.ForwardB_E[2*l +: 2]  = fb[l];
            bus.FwdLaneA_E[l] = la[l];
            bus.FwdLaneB_E[l] = lb[l];
            bus.RD_E[5*l +: 5]        = rdn[l];
            bus.RD1_E[32*l +: 32]     = rd1[l];
            bus.RD2_E[32*l +: 32]     = rd2[l];
            bus.Imm_Ext_E[32*l +: 32] = imm[l];
            bus.PCE[32*l +: 32]       = pc[l];
            bus.PCPlus4E[32*l +: 32]  = pc4[l];
            bus.ResultW[32*l +: 32]   = resw[l];
        end
        bus.StallM = stall;
        bus.FlushM = flush;
    endtask

    // Expected redirect and next M contents from the current inputs
    task automatic ref_eval();
        bit [31:0] a, bi, b, r;
        bit [31:0] res[N], sbi[N], tgt[N];
        bit        tk[N];
        bit        found;
        int        k;
        for (int l = 0; l < N; l++) begin
            a  = opnd(fa[l], la[l], rd1[l]);
            bi = opnd(fb[l], lb[l], rd2[l]);
            b  = asrc[l] ? imm[l] : bi;
            r  = ref_alu(op[l], a, b);
            res[l] = r;
            sbi[l] = bi;
            tgt[l] = pc[l] + imm[l];
            tk[l]  = v[l] && br[l] && (r == 0);
        end
        found = 0;
        k = 0;
        for (int l = N - 1; l >= 0; l--) if (tk[l]) begin found = 1; k = l; end
        e_pcsrc = found && !stall;
        e_tgt   = tgt[k];
        e_br    = k;
        for (int l = 0; l < N; l++) begin
            if (flush) begin
                n_v[l] = 0; n_rw[l] = 0; n_mw[l] = 0; n_rs[l] = 0; n_rd[l] = 0;
                n_alu[l] = 0; n_wd[l] = 0; n_pc4[l] = 0;
            end else if (stall) begin
                n_v[l] = m_v[l]; n_rw[l] = m_rw[l]; n_mw[l] = m_mw[l]; n_rs[l] = m_rs[l];
                n_rd[l] = m_rd[l]; n_alu[l] = m_alu[l]; n_wd[l] = m_wd[l]; n_pc4[l] = m_pc4[l];
            end else begin
                bit live;
                live = v[l] && !(found && l > k);
                n_v[l] = live; n_rw[l] = rw[l] && live; n_mw[l] = mw[l] && live;
                n_rs[l] = rs[l]; n_rd[l] = rdn[l]; n_alu[l] = res[l];
                n_wd[l] = sbi[l]; n_pc4[l] = pc4[l];
            end
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < N; l++) begin
            m_v[l] = 0; m_rw[l] = 0; m_mw[l] = 0; m_rs[l] = 0; m_rd[l] = 0;
            m_alu[l] = 0; m_wd[l] = 0; m_pc4[l] = 0;
        end
    endtask

    task automatic check_regs(input string tag);
        logic [N-1:0]    ev, erw, emw, ers;
        logic [5*N-1:0]  erd;
        logic [32*N-1:0] ealu, ewd, epc4;
        for (int l = 0; l < N; l++) begin
            ev[l] = m_v[l]; erw[l] = m_rw[l]; emw[l] = m_mw[l]; ers[l] = m_rs[l];
            erd[5*l +: 5] = m_rd[l];
            ealu[32*l +: 32] = m_alu[l];
            ewd[32*l +: 32]  = m_wd[l];
            epc4[32*l +: 32] = m_pc4[l];
        end
        chk({tag, ".ValidM"},      64'(bus.ValidM),     64'(ev));
        chk({tag, ".RegWriteM"},   64'(bus.RegWriteM),  64'(erw));
        chk({tag, ".MemWriteM"},   64'(bus.MemWriteM),  64'(emw));
        chk({tag, ".ResultSrcM"},  64'(bus.ResultSrcM), 64'(ers));
        chk({tag, ".RD_M"},        64'(bus.RD_M),       64'(erd));
        chk({tag, ".ALU_ResultM"}, bus.ALU_ResultM,     ealu);
        chk({tag, ".WriteDataM"},  bus.WriteDataM,      ewd);
        chk({tag, ".PCPlus4M"},    bus.PCPlus4M,        epc4);
    endtask

    // One clock: drive after negedge, check redirect, clock in, check M.
    task automatic cycle(input string tag);
        pack_inputs();
        #1;
        ref_eval();
        o_pcsrc = bus.PCSrcE;
        o_tgt   = bus.PCTargetE;
        o_br    = bus.BrLaneE;
        chk({tag, ".PCSrcE"},    64'(o_pcsrc), 64'(e_pcsrc));
        chk({tag, ".PCTargetE"}, 64'(o_tgt),   64'(e_tgt));
        chk({tag, ".BrLaneE"},   64'(o_br),    64'(e_br));
        @(posedge clk);
        #1;
        m_v = n_v; m_rw = n_rw; m_mw = n_mw; m_rs = n_rs;
        m_rd = n_rd; m_alu = n_alu; m_wd = n_wd; m_pc4 = n_pc4;
        check_regs(tag);
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        for (int l = 0; l < N; l++) begin
            v[l]    = ($urandom_range(0, 3) != 0);
            rw[l]   = 1'($urandom);
            mw[l]   = 1'($urandom);
            rs[l]   = 1'($urandom);
            br[l]   = ($urandom_range(0, 2) == 0);
            op[l]   = 3'($urandom);
            asrc[l] = 1'($urandom);
            rd1[l]  = $urandom_range(0, 1) ? 32'($urandom_range(0, 7)) : $urandom;
            rd2[l]  = $urandom_range(0, 1) ? 32'($urandom_range(0, 7)) : $urandom;
            imm[l]  = $urandom_range(0, 1) ? 32'($urandom_range(0, 7)) : $urandom;
            if (br[l] && $urandom_range(0, 1) == 1) begin
                op[l] = 3'd1; asrc[l] = 0; rd2[l] = rd1[l];
            end
            fa[l]   = 2'($urandom);
            fb[l]   = 2'($urandom);
            la[l]   = 1'($urandom);
            lb[l]   = 1'($urandom);
            rdn[l]  = 5'($urandom);
            pc[l]   = $urandom;
            pc4[l]  = pc[l] + 32'd4;
            resw[l] = $urandom_range(0, 1) ? 32'($urandom_range(0, 7)) : $urandom;
        end
        stall = ($urandom_range(0, 4) == 0);
        flush = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        // Reset asserted from time 0
        rst = 1'b0;
        clear_inputs();
        pack_inputs();
        model_reset();
        #3;
        check_regs("reset");

        // Lane 0 ADD 5+7, lane 1 SUB 10-imm 3; reset released mid-cycle
        @(negedge clk);
        clear_inputs();
        v[0] = 1; rw[0] = 1; op[0] = 3'd0; rd1[0] = 5;  rd2[0] = 7;  rdn[0] = 5'd3;
        v[1] = 1; rw[1] = 1; op[1] = 3'd1; rd1[1] = 10; imm[1] = 3; asrc[1] = 1; rdn[1] = 5'd4;
        rst = 1'b1;
        cycle("addsub");
        chk("addsub.alu", bus.ALU_ResultM, {32'd7, 32'd12});
        chk("addsub.valid", 64'(bus.ValidM), 64'(2'b11));

        // SLT -1 < 1, SLL 1 by 31
        clear_inputs();
        v[0] = 1; op[0] = 3'd5; rd1[0] = 32'hFFFF_FFFF; rd2[0] = 1;
        v[1] = 1; op[1] = 3'd6; rd1[1] = 1; rd2[1] = 31;
        cycle("sltsll");
        chk("sltsll.alu", bus.ALU_ResultM, {32'h8000_0000, 32'd1});

        // Back-to-back forward from M
        clear_inputs();
        v[0] = 1; op[0] = 3'd0; rd1[0] = 32'h10;
        cycle("fwd1");
        clear_inputs();
        v[1] = 1; op[1] = 3'd0; fa[1] = 2'b10; la[1] = 0; imm[1] = 1; asrc[1] = 1;
        cycle("fwd2");
        chk("fwdM.lane1", 64'(bus.ALU_ResultM[63:32]), 64'h11);

        // Lane 0 taken branch squashes lane 1 store
        clear_inputs();
        v[0] = 1; br[0] = 1; op[0] = 3'd1; rd1[0] = 4; rd2[0] = 4; pc[0] = 32'h100; imm[0] = 32'h20;
        v[1] = 1; mw[1] = 1; op[1] = 3'd0; rd1[1] = 32'h40; rd2[1] = 32'hAB;
        cycle("squash");
        chk("squash.pcsrc",  64'(o_pcsrc), 64'd1);
        chk("squash.target", 64'(o_tgt),   64'h120);
        chk("squash.brlane", 64'(o_br),    64'd0);
        chk("squash.memw1",  64'(bus.MemWriteM[1]), 64'd0);
        chk("squash.valid",  64'(bus.ValidM), 64'(2'b01));

        // Both lanes taken: oldest wins; then only lane 1
        v[1] = 1; br[1] = 1; mw[1] = 0; op[1] = 3'd1; rd1[1] = 9; rd2[1] = 9;
        pc[1] = 32'h200; imm[1] = 32'h40;
        pack_inputs();
        #1;
        chk("both.brlane", 64'(bus.BrLaneE), 64'd0);
        v[0] = 0;
        pack_inputs();
        #1;
        chk("lane1.brlane", 64'(bus.BrLaneE),   64'd1);
        chk("lane1.target", 64'(bus.PCTargetE), 64'h240);
        cycle("lane1br");

        // Load, stall twice with a taken branch, then flush+stall
        clear_inputs();
        v[0] = 1; rw[0] = 1; op[0] = 3'd3; rd1[0] = 32'hF0; rd2[0] = 32'h0F; rdn[0] = 5'd7;
        v[1] = 1; rw[1] = 1; op[1] = 3'd4; rd1[1] = 32'hFF; rd2[1] = 32'h0F; rdn[1] = 5'd9;
        cycle("preload");
        clear_inputs();
        v[0] = 1; br[0] = 1; op[0] = 3'd1; rd1[0] = 2; rd2[0] = 2; pc[0] = 32'h300; imm[0] = 8;
        v[1] = 1; rw[1] = 1; rd1[1] = 77;
        stall = 1;
        cycle("stall1");
        chk("stall1.pcsrc", 64'(o_pcsrc), 64'd0);
        cycle("stall2");
        chk("stall2.pcsrc", 64'(o_pcsrc), 64'd0);
        chk("stall2.valid", 64'(bus.ValidM), 64'(2'b11));
        flush = 1;
        cycle("flushstall");
        chk("flush.valid", 64'(bus.ValidM),    64'd0);
        chk("flush.regw",  64'(bus.RegWriteM), 64'd0);
        chk("flush.memw",  64'(bus.MemWriteM), 64'd0);

        // Randomised traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            cycle("rand");
        end

        // Asynchronous reset mid-cycle
        clear_inputs();
        v[0] = 1; rw[0] = 1; mw[1] = 1; v[1] = 1; op[0] = 3'd0; rd1[0] = 32'h55; rd1[1] = 3;
        cycle("prereset");
        clear_inputs();
        v[0] = 1; br[0] = 1; op[0] = 3'd1; rd1[0] = 6; rd2[0] = 6; pc[0] = 32'h400; imm[0] = 4;
        v[1] = 1; rw[1] = 1;
        pack_inputs();
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check_regs("asyncrst");
        chk("asyncrst.pcsrc", 64'(bus.PCSrcE), 64'd1);
        rst = 1'b1;
        cycle("postreset");
        chk("postreset.valid", 64'(bus.ValidM), 64'(2'b01));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard bound on simulation time
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
